// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a per-register
// pending (scoreboard) bit that is set on issue and cleared on writeback.
module reg_file_sb #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned INIT_INDEX = 1,
    localparam int unsigned AW        = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs1_add,
    input  logic [AW-1:0]    rs2_add,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_waw,
    input  logic             reg_write,
    input  logic [AW-1:0]    rd_add,
    input  logic [XLEN-1:0]  write_reg_data,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic             wr_en;
    logic             iss_en;

    function automatic logic [XLEN-1:0] reset_val(input int idx);
        if (INIT_INDEX == 0 || (ZERO_REG != 0 && idx == 0)) begin
            return '0;
        end
        return XLEN'(idx);
    endfunction

    // Register 0 is hard-wired when ZERO_REG is set, so writes and issues to it vanish here.
    always_comb begin
        wr_en  = reg_write;
        iss_en = issue_valid;
        if (ZERO_REG != 0 && rd_add == '0) begin
            wr_en = 1'b0;
        end
        if (ZERO_REG != 0 && issue_rd == '0) begin
            iss_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= reset_val(i);
            end
        end else if (wr_en) begin
            regs_q[rd_add] <= write_reg_data;
        end
    end

    // Issue is applied after writeback so a same-register collision leaves the bit set:
    // the newly issued producer owns the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (iss_en && issue_rd == AW'(i)) begin
                    busy_q[i] <= 1'b1;
                end else if (wr_en && rd_add == AW'(i)) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_add];
        rs1_busy = busy_q[rs1_add];
        if (BYPASS != 0 && wr_en && rd_add == rs1_add) begin
            rs1_data = write_reg_data;
            rs1_busy = 1'b0;
        end
        if (ZERO_REG != 0 && rs1_add == '0) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_add];
        rs2_busy = busy_q[rs2_add];
        if (BYPASS != 0 && wr_en && rd_add == rs2_add) begin
            rs2_data = write_reg_data;
            rs2_busy = 1'b0;
        end
        if (ZERO_REG != 0 && rs2_add == '0) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
        end
    end

    // Advisory only: uses the pre-edge pending bit, never the bypassed view.
    assign issue_waw = issue_valid && busy_q[issue_rd];
    assign busy_vec  = busy_q;

endmodule
